// File: rtl/segment_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : segment_sequencer
//  Purpose  : Plays per-channel ROM segments, advancing channels sequentially
//             or by latched requests, with a free-running sub-sample tick.
//  Revision : 1.0  initial release
// ============================================================================
module segment_sequencer #(
    parameter int NCH      = 4,
    parameter int DW       = 8,
    parameter int CW       = 8,
    parameter int TICK_DIV = 11,
    localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              auto,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    latch_sel,
    input  logic [NCH*DW-1:0] rom_data,
    input  logic [NCH*CW-1:0] seg_len,
    output logic [DW-1:0]     data_out,
    output logic [CW-1:0]     count,
    output logic [SW-1:0]     chan,
    output logic              seg_done,
    output logic              tick
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_DIV_LAST = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] c_LAST_CH  = SW'(NCH - 1);

    state_t          w_state;
    logic [CW-1:0]   r_div;
    logic [SW-1:0]   w_idle_chan;
    logic [SW-1:0]   w_rr_chan;
    logic            w_rr_found;
    logic [SW-1:0]   w_seq_chan;
    logic [SW-1:0]   w_next_chan;
    logic [CW-1:0]   w_cur_len;
    logic            w_seg_end;

    assign w_state = run ? PLAY : IDLE;

    // Lowest enabled channel wins; descending scan leaves the lowest index last.
    always_comb begin
        w_idle_chan = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (en[k]) begin
                w_idle_chan = SW'(k);
            end
        end
    end

    // Round-robin search starting after the current channel and ending on it.
    always_comb begin
        w_rr_chan  = chan;
        w_rr_found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            if (!w_rr_found && latch_sel[(int'(chan) + i) % NCH]) begin
                w_rr_chan  = SW'((int'(chan) + i) % NCH);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_seq_chan  = (chan == c_LAST_CH) ? '0 : chan + 1'b1;
    assign w_next_chan = auto ? w_rr_chan : w_seq_chan;
    assign w_cur_len   = seg_len[chan*CW +: CW];
    assign w_seg_end   = (count == w_cur_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            count    <= '0;
            chan     <= '0;
            seg_done <= 1'b0;
            tick     <= 1'b0;
            r_div    <= '0;
        end else begin
            case (w_state)
                IDLE: begin
                    data_out <= '0;
                    count    <= '0;
                    chan     <= w_idle_chan;
                    seg_done <= 1'b0;
                    tick     <= 1'b0;
                    r_div    <= '0;
                end
                PLAY: begin
                    data_out <= en[chan] ? rom_data[chan*DW +: DW] : '0;
                    // A shortened seg_len below count lets count wrap naturally.
                    if (w_seg_end) begin
                        count    <= '0;
                        seg_done <= 1'b1;
                        chan     <= w_next_chan;
                    end else begin
                        count    <= count + 1'b1;
                        seg_done <= 1'b0;
                    end
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        tick  <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                        tick  <= 1'b0;
                    end
                end
                default: begin
                    data_out <= '0;
                    count    <= '0;
                    seg_done <= 1'b0;
                    tick     <= 1'b0;
                    r_div    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_segment_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segment_sequencer
//  Purpose  : Directed self-checking bench for segment_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_segment_sequencer;

    localparam int NCH      = 4;
    localparam int DW       = 8;
    localparam int CW       = 8;
    localparam int TICK_DIV = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              auto;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    latch_sel;
    logic [NCH*DW-1:0] rom_data;
    logic [NCH*CW-1:0] seg_len;
    logic [DW-1:0]     data_out;
    logic [CW-1:0]     count;
    logic [1:0]        chan;
    logic              seg_done;
    logic              tick;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    segment_sequencer #(
        .NCH      (NCH),
        .DW       (DW),
        .CW       (CW),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .auto      (auto),
        .en        (en),
        .latch_sel (latch_sel),
        .rom_data  (rom_data),
        .seg_len   (seg_len),
        .data_out  (data_out),
        .count     (count),
        .chan      (chan),
        .seg_done  (seg_done),
        .tick      (tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; auto = 1'b0; en = 4'hF; latch_sel = 4'h0;
        rom_data = {8'h3C, 8'hA5, 8'h22, 8'h11};
        seg_len  = {8'd54, 8'd87, 8'd120, 8'd131};
        step(); step();
        n_total++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h expected 00", data_out); else n_pass++;
        n_total++; if (count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_total++; if (chan !== 2'd0) $display("FAIL reset_chan: got %0d expected 0", chan); else n_pass++;
        n_total++; if (seg_done !== 1'b0) $display("FAIL reset_seg_done: got %b expected 0", seg_done); else n_pass++;
        n_total++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", tick); else n_pass++;
        run = 1'b0; en = 4'b0100; rst = 1'b0;
        step();
        n_total++; if (chan !== 2'd2) $display("FAIL release_idle_chan: got %0d expected 2", chan); else n_pass++;
        n_total++; if (count !== 8'd0) $display("FAIL release_idle_count: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_sequential();
        int lens[4]  = '{132, 121, 88, 55};
        int lasts[4] = '{131, 120, 87, 54};
        int n;
        int prev;
        logic seen;
        seg_len = {8'd54, 8'd87, 8'd120, 8'd131};
        en = 4'hF; auto = 1'b0; run = 1'b0;
        step();
        n_total++; if (chan !== 2'd0) $display("FAIL seq_start_chan: got %0d expected 0", chan); else n_pass++;
        run = 1'b1;
        for (int s = 0; s < 4; s++) begin
            n = 0; prev = 0; seen = 1'b0;
            while (!seen && n < 400) begin
                prev = int'(count);
                step();
                n++;
                seen = seg_done;
            end
            n_total++; if (n != lens[s]) $display("FAIL seq_len_%0d: got %0d cycles expected %0d", s, n, lens[s]); else n_pass++;
            n_total++; if (prev != lasts[s]) $display("FAIL seq_last_count_%0d: got %0d expected %0d", s, prev, lasts[s]); else n_pass++;
            n_total++; if (chan !== 2'((s + 1) % 4)) $display("FAIL seq_next_chan_%0d: got %0d expected %0d", s, chan, (s + 1) % 4); else n_pass++;
        end
        run = 1'b0;
        step();
    endtask

    task automatic test_auto();
        int n;
        seg_len = {8'd3, 8'd4, 8'd5, 8'd6};
        en = 4'b0010; auto = 1'b1; latch_sel = 4'b0001; run = 1'b0;
        step();
        n_total++; if (chan !== 2'd1) $display("FAIL auto_start_chan: got %0d expected 1", chan); else n_pass++;
        run = 1'b1;
        n = 0;
        do begin step(); n++; end while (!seg_done && n < 20);
        n_total++; if (n != 6 || chan !== 2'd0) $display("FAIL auto_latch0: got len %0d chan %0d expected len 6 chan 0", n, chan); else n_pass++;
        run = 1'b0; step();
        latch_sel = 4'b0000; run = 1'b1;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin step(); n++; end while (!seg_done && n < 20);
            n_total++; if (n != 6 || chan !== 2'd1) $display("FAIL auto_repeat_%0d: got len %0d chan %0d expected len 6 chan 1", r, n, chan); else n_pass++;
        end
        run = 1'b0; step();
        latch_sel = 4'b1001; run = 1'b1;
        n = 0;
        do begin step(); n++; end while (!seg_done && n < 20);
        n_total++; if (n != 6 || chan !== 2'd3) $display("FAIL auto_round_robin: got len %0d chan %0d expected len 6 chan 3", n, chan); else n_pass++;
        run = 1'b0; auto = 1'b0; latch_sel = 4'b0000;
        step();
    endtask

    task automatic test_enable();
        run = 1'b0; en = 4'b0100;
        step();
        n_total++; if (chan !== 2'd2 || data_out !== 8'h00) $display("FAIL en_idle: got chan %0d data %h expected chan 2 data 00", chan, data_out); else n_pass++;
        run = 1'b1;
        step();
        n_total++; if (data_out !== 8'hA5) $display("FAIL en_first_data: got %h expected a5", data_out); else n_pass++;
        n_total++; if (count !== 8'd1) $display("FAIL en_first_count: got %0d expected 1", count); else n_pass++;
        en = 4'b0000;
        step();
        n_total++; if (data_out !== 8'h00 || count !== 8'd2 || chan !== 2'd2) $display("FAIL en_cleared: got data %h count %0d chan %0d expected 00 2 2", data_out, count, chan); else n_pass++;
        step(); step(); step();
        n_total++; if (seg_done !== 1'b1 || chan !== 2'd3) $display("FAIL en_full_segment: got seg_done %b chan %0d expected 1 3", seg_done, chan); else n_pass++;
        run = 1'b0;
        step();
    endtask

    task automatic test_tick();
        int ticks;
        run = 1'b0; en = 4'hF;
        step();
        n_total++; if (tick !== 1'b0) $display("FAIL tick_idle: got %b expected 0", tick); else n_pass++;
        run = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (tick) begin
                ticks++;
                n_total++; if (k != 11 * ticks) $display("FAIL tick_position: got cycle %0d expected %0d", k, 11 * ticks); else n_pass++;
            end
        end
        n_total++; if (ticks != 3) $display("FAIL tick_count: got %0d expected 3", ticks); else n_pass++;
        run = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        int n;
        seg_len = {8'd3, 8'd100, 8'd5, 8'd6};
        run = 1'b0; en = 4'b0100;
        step();
        run = 1'b1;
        repeat (40) step();
        n_total++; if (count !== 8'd40 || data_out !== 8'hA5) $display("FAIL areset_pre: got count %0d data %h expected 40 a5", count, data_out); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (count !== 8'd0 || data_out !== 8'h00 || chan !== 2'd0 || seg_done !== 1'b0 || tick !== 1'b0)
            $display("FAIL areset_async: got count %0d data %h chan %0d seg_done %b tick %b expected all 0", count, data_out, chan, seg_done, tick);
        else n_pass++;
        step();
        rst = 1'b0;
        n = 0;
        do begin step(); n++; end while (!tick && n < 20);
        n_total++; if (n != 11) $display("FAIL areset_divider: got first tick after %0d cycles expected 11", n); else n_pass++;
        run = 1'b0; step();
        run = 1'b1;
        repeat (10) step();
        n_total++; if (count !== 8'd10) $display("FAIL stop_pre_count: got %0d expected 10", count); else n_pass++;
        run = 1'b0;
        step();
        n_total++; if (count !== 8'd0 || data_out !== 8'h00 || chan !== 2'd2) $display("FAIL stop_midsegment: got count %0d data %h chan %0d expected 0 00 2", count, data_out, chan); else n_pass++;
    endtask

    task automatic test_zero_len();
        seg_len = '0; en = 4'hF; auto = 1'b0; run = 1'b0;
        step();
        run = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_total++; if (seg_done !== 1'b1 || chan !== 2'(k % 4) || count !== 8'd0)
                $display("FAIL zero_len_%0d: got seg_done %b chan %0d count %0d expected 1 %0d 0", k, seg_done, chan, count, k % 4);
            else n_pass++;
        end
        run = 1'b0;
        step();
    endtask

    task automatic test_len_change();
        int n;
        seg_len = {8'd0, 8'd0, 8'd0, 8'd10}; en = 4'h1; auto = 1'b0; run = 1'b0;
        step();
        run = 1'b1;
        repeat (8) step();
        n_total++; if (count !== 8'd8) $display("FAIL len_change_pre: got %0d expected 8", count); else n_pass++;
        seg_len = {8'd0, 8'd0, 8'd0, 8'd5};
        n = 0;
        do begin step(); n++; end while (!seg_done && n < 300);
        n_total++; if (n != 254 || chan !== 2'd1) $display("FAIL len_change_wrap: got %0d cycles chan %0d expected 254 chan 1", n, chan); else n_pass++;
        run = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_auto();
        test_enable();
        test_tick();
        test_async_reset();
        test_zero_len();
        test_len_change();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
